// File: rtl/fpu_share_ctrl_pkg.sv
// Op-select encodings, per-op settle latency and controller state encoding
// shared by the FPU sharing controller and its arbiter.
package fpu_share_ctrl_pkg;

    localparam logic [4:0] FPU_FWD      = 5'b00000;
    localparam logic [4:0] FPU_FADD     = 5'b00001;
    localparam logic [4:0] FPU_FSUB     = 5'b00010;
    localparam logic [4:0] FPU_FMUL     = 5'b00011;
    localparam logic [4:0] FPU_FDIV     = 5'b00100;
    localparam logic [4:0] FPU_FSQRT    = 5'b00101;
    localparam logic [4:0] FPU_FSGNJ    = 5'b00110;
    localparam logic [4:0] FPU_FSGNJN   = 5'b00111;
    localparam logic [4:0] FPU_FSGNJX   = 5'b01000;
    localparam logic [4:0] FPU_FMIN     = 5'b01001;
    localparam logic [4:0] FPU_FMAX     = 5'b01010;
    localparam logic [4:0] FPU_FCVT_W_S = 5'b01011;
    localparam logic [4:0] FPU_FCVT_WU_S = 5'b01100;
    localparam logic [4:0] FPU_FCVT_S_W = 5'b01101;
    localparam logic [4:0] FPU_FMADD    = 5'b01110;
    localparam logic [4:0] FPU_FMSUB    = 5'b01111;
    localparam logic [4:0] FPU_FNMADD   = 5'b10000;
    localparam logic [4:0] FPU_FNMSUB   = 5'b10001;
    localparam logic [4:0] FPU_FEQ      = 5'b10010;
    localparam logic [4:0] FPU_FLT      = 5'b10011;
    localparam logic [4:0] FPU_FCLASS   = 5'b10100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic is_fma(input logic [4:0] sel);
        return (sel >= FPU_FMADD) && (sel <= FPU_FNMSUB);
    endfunction

    // Encodings outside the known set fall through to the base latency.
    function automatic int op_lat(input logic [4:0] sel, input int base_lat,
                                  input int fma_lat, input int div_lat);
        if (sel == FPU_FDIV)
            return div_lat;
        if (is_fma(sel))
            return fma_lat;
        return base_lat;
    endfunction

endpackage

// File: rtl/fpu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            pos = IDX_W'((int'(ptr) + i) % N);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/fpu_share_ctrl.sv
// Shares one combinational FPU between N_REQ requesters: round-robin accept,
// registered operands, op-dependent settle wait, tagged result return.
module fpu_share_ctrl
    import fpu_share_ctrl_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int BASE_LAT = 1,
    parameter int FMA_LAT  = 2,
    parameter int DIV_LAT  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [5*N_REQ-1:0]    req_select,
    input  logic [32*N_REQ-1:0]   req_data1,
    input  logic [32*N_REQ-1:0]   req_data2,
    input  logic [32*N_REQ-1:0]   req_data3,
    output logic [N_REQ-1:0]      grant,
    output logic [31:0]           fpu_data1,
    output logic [31:0]           fpu_data2,
    output logic [31:0]           fpu_data3,
    output logic [4:0]            fpu_select,
    input  logic [31:0]           fpu_result,
    output logic                  resp_valid,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_result,
    output logic                  busy
);

    localparam int MAX_LAT = (DIV_LAT > FMA_LAT)
                           ? ((DIV_LAT > BASE_LAT) ? DIV_LAT : BASE_LAT)
                           : ((FMA_LAT > BASE_LAT) ? FMA_LAT : BASE_LAT);
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   tag;
    logic [CNT_W-1:0]  cnt;

    logic [N_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]   arb_idx;

    logic [4:0]        sel_arr [N_REQ];
    logic [31:0]       d1_arr  [N_REQ];
    logic [31:0]       d2_arr  [N_REQ];
    logic [31:0]       d3_arr  [N_REQ];

    logic [4:0]        win_sel;
    logic [CNT_W-1:0]  win_cnt;
    logic [ID_W-1:0]   next_ptr;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign sel_arr[g] = req_select[5*g +: 5];
        assign d1_arr[g]  = req_data1[32*g +: 32];
        assign d2_arr[g]  = req_data2[32*g +: 32];
        assign d3_arr[g]  = req_data3[32*g +: 32];
    end

    // cnt is preloaded with LAT-1 so the result is captured on the LAT-th EXEC edge.
    always_comb begin
        win_sel  = sel_arr[arb_idx];
        win_cnt  = CNT_W'(op_lat(win_sel, BASE_LAT, FMA_LAT, DIV_LAT) - 1);
        next_ptr = (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            tag         <= '0;
            cnt         <= '0;
            grant       <= '0;
            fpu_data1   <= '0;
            fpu_data2   <= '0;
            fpu_data3   <= '0;
            fpu_select  <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        fpu_data1  <= d1_arr[arb_idx];
                        fpu_data2  <= d2_arr[arb_idx];
                        fpu_data3  <= d3_arr[arb_idx];
                        fpu_select <= win_sel;
                        grant      <= arb_gnt;
                        cnt        <= win_cnt;
                        tag        <= arb_idx;
                        ptr        <= next_ptr;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    grant <= '0;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        resp_result <= fpu_result;
                        resp_id     <= tag;
                        resp_valid  <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    grant      <= '0;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_share_ctrl.sv
// Self-checking bench for fpu_share_ctrl with a behavioural FPU stand-in and
// a round-robin / latency reference model.
module tb_fpu_share_ctrl;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [19:0]   req_select;
    logic [127:0]  req_data1;
    logic [127:0]  req_data2;
    logic [127:0]  req_data3;
    logic [3:0]    grant;
    logic [31:0]   fpu_data1;
    logic [31:0]   fpu_data2;
    logic [31:0]   fpu_data3;
    logic [4:0]    fpu_select;
    logic [31:0]   fpu_result;
    logic          resp_valid;
    logic [1:0]    resp_id;
    logic [31:0]   resp_result;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int model_ptr = 0;

    fpu_share_ctrl #(
        .N_REQ    (4),
        .ID_W     (2),
        .BASE_LAT (1),
        .FMA_LAT  (2),
        .DIV_LAT  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_select  (req_select),
        .req_data1   (req_data1),
        .req_data2   (req_data2),
        .req_data3   (req_data3),
        .grant       (grant),
        .fpu_data1   (fpu_data1),
        .fpu_data2   (fpu_data2),
        .fpu_data3   (fpu_data3),
        .fpu_select  (fpu_select),
        .fpu_result  (fpu_result),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic real to_real(input logic [31:0] f);
        if (f[30:0] == 31'd0)
            return 0.0;
        return $bitstoreal({f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] from_real(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0)
            return 32'd0;
        d = $realtobits(r);
        e = d[62:52];
        return {d[63], 8'(e - 11'd896), d[51:29]};
    endfunction

    // Stand-in FPU: real arithmetic for the ops the bench exercises numerically,
    // a reproducible bit mix for the rest, zero for unknown encodings.
    function automatic logic [31:0] fpu_model(input logic [4:0] sel, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c);
        case (sel)
            5'd1:  return from_real(to_real(a) + to_real(b));
            5'd2:  return from_real(to_real(a) - to_real(b));
            5'd3:  return from_real(to_real(a) * to_real(b));
            5'd4:  return (to_real(b) == 0.0) ? 32'd0 : from_real(to_real(a) / to_real(b));
            5'd14: return from_real(to_real(a) * to_real(b) + to_real(c));
            default: begin
                if (sel > 5'd20)
                    return 32'd0;
                return a ^ {b[15:0], b[31:16]} ^ c ^ {27'd0, sel};
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] sel);
        if (sel == 5'd4)
            return 4;
        if (sel >= 5'd14 && sel <= 5'd17)
            return 2;
        return 1;
    endfunction

    function automatic int pick(input logic [3:0] mask, input int p);
        for (int i = 0; i < N; i++) begin
            if (mask[(p + i) % N])
                return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] nice();
        return from_real(real'($urandom_range(1, 8)));
    endfunction

    assign fpu_result = fpu_model(fpu_select, fpu_data1, fpu_data2, fpu_data3);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int k, input logic [4:0] sel, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] c);
        req_select[5*k +: 5]  = sel;
        req_data1[32*k +: 32] = a;
        req_data2[32*k +: 32] = b;
        req_data3[32*k +: 32] = c;
        req[k]                = 1'b1;
    endtask

    // Waits for the accept of requester k, checks the registered FPU inputs,
    // settle time, tagged result and the one-cycle strobes.
    task automatic expect_txn(input int k, input logic [31:0] exp_res, input string tag,
                              input bit keep, input bit scramble, output int wait_cycles);
        logic [4:0]  sel;
        logic [31:0] a, b, c;
        int n, l;
        sel = req_select[5*k +: 5];
        a   = req_data1[32*k +: 32];
        b   = req_data2[32*k +: 32];
        c   = req_data3[32*k +: 32];
        n = 0;
        while (grant == 4'd0 && n < 30) begin
            tick();
            n++;
        end
        wait_cycles = n;
        check_output({tag, ".grant"}, 32'(grant), 32'(1 << k));
        check_output({tag, ".fpu_select"}, 32'(fpu_select), 32'(sel));
        check_output({tag, ".fpu_data1"}, fpu_data1, a);
        check_output({tag, ".fpu_data2"}, fpu_data2, b);
        check_output({tag, ".fpu_data3"}, fpu_data3, c);
        check_output({tag, ".busy_grant"}, 32'(busy), 32'd1);
        model_ptr = (k + 1) % N;
        if (!keep)
            req[k] = 1'b0;
        if (scramble)
            req_data1[32*k +: 32] = ~a;
        l = 0;
        while (!resp_valid && l < 30) begin
            tick();
            l++;
            if (l == 1)
                check_output({tag, ".grant_pulse"}, 32'(grant), 32'd0);
            if (!resp_valid)
                check_output({tag, ".busy_exec"}, 32'(busy), 32'd1);
        end
        check_output({tag, ".latency"}, 32'(l), 32'(model_lat(sel)));
        check_output({tag, ".resp_id"}, 32'(resp_id), 32'(k));
        check_output({tag, ".resp_result"}, resp_result, exp_res);
        check_output({tag, ".busy_done"}, 32'(busy), 32'd1);
        check_output({tag, ".operand_hold"}, fpu_data1, a);
        tick();
        check_output({tag, ".resp_strobe"}, 32'(resp_valid), 32'd0);
        check_output({tag, ".busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int w;
        int k;
        int exp_order [5];
        logic [3:0] mask;
        logic [4:0] rsel;
        logic [31:0] ra, rb, rc;

        exp_order = '{0, 1, 2, 3, 0};
        rst        = 1'b1;
        req        = '0;
        req_select = '0;
        req_data1  = '0;
        req_data2  = '0;
        req_data3  = '0;
        #1;
        check_output("reset.grant", 32'(grant), 32'd0);
        check_output("reset.busy", 32'(busy), 32'd0);
        check_output("reset.resp_valid", 32'(resp_valid), 32'd0);
        check_output("reset.fpu_select", 32'(fpu_select), 32'd0);
        check_output("reset.resp_result", resp_result, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_output("idle.grant", 32'(grant), 32'd0);
        check_output("idle.busy", 32'(busy), 32'd0);

        $display("[TB] single FADD");
        apply_stimulus(0, 5'd1, 32'h3F800000, 32'h40000000, 32'h0);
        expect_txn(0, 32'h40400000, "fadd", 1'b0, 1'b0, w);

        $display("[TB] FDIV latency");
        apply_stimulus(2, 5'd4, 32'h40C00000, 32'h40000000, 32'h0);
        expect_txn(2, 32'h40400000, "fdiv", 1'b0, 1'b0, w);

        $display("[TB] FMADD from requester 3");
        apply_stimulus(3, 5'd14, 32'h40000000, 32'h40400000, 32'h3F800000);
        expect_txn(3, 32'h40E00000, "fmadd", 1'b0, 1'b0, w);

        $display("[TB] round robin, all requesters held");
        for (int i = 0; i < N; i++)
            apply_stimulus(i, 5'd3, nice(), nice(), 32'h0);
        for (int t = 0; t < 5; t++) begin
            k = exp_order[t];
            expect_txn(k, fpu_model(5'd3, req_data1[32*k +: 32], req_data2[32*k +: 32], 32'h0),
                       $sformatf("rr%0d", t), 1'b1, 1'b0, w);
            if (t > 0)
                check_output($sformatf("rr%0d.spacing", t), 32'(w), 32'd1);
        end
        req = '0;

        $display("[TB] operand isolation");
        apply_stimulus(1, 5'd4, nice(), nice(), nice());
        expect_txn(1, fpu_model(5'd4, req_data1[63:32], req_data2[63:32], req_data3[63:32]),
                   "isolate", 1'b0, 1'b1, w);

        $display("[TB] reset mid-operation");
        apply_stimulus(1, 5'd4, 32'h40C00000, 32'h40000000, 32'h3F800000);
        w = 0;
        while (grant == 4'd0 && w < 30) begin
            tick();
            w++;
        end
        check_output("midrst.grant", 32'(grant), 32'd2);
        req = '0;
        tick();
        rst = 1'b1;
        #1;
        check_output("midrst.grant0", 32'(grant), 32'd0);
        check_output("midrst.busy0", 32'(busy), 32'd0);
        check_output("midrst.fpu_select0", 32'(fpu_select), 32'd0);
        check_output("midrst.fpu_data1", fpu_data1, 32'd0);
        check_output("midrst.fpu_data3", fpu_data3, 32'd0);
        check_output("midrst.resp_valid0", 32'(resp_valid), 32'd0);
        tick();
        rst = 1'b0;
        model_ptr = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_output($sformatf("midrst.no_resp%0d", i), 32'(resp_valid), 32'd0);
        end
        apply_stimulus(1, 5'd1, 32'h3F800000, 32'h3F800000, 32'h0);
        apply_stimulus(3, 5'd3, 32'h40000000, 32'h40000000, 32'h0);
        k = pick(req, model_ptr);
        expect_txn(k, 32'h40000000, "postrst", 1'b0, 1'b0, w);
        k = pick(req, model_ptr);
        expect_txn(k, 32'h40800000, "postrst2", 1'b0, 1'b0, w);
        req = '0;

        $display("[TB] randomized traffic");
        for (int it = 0; it < 30; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    rsel = 5'($urandom_range(0, 23));
                    apply_stimulus(i, rsel, nice(), nice(), nice());
                end
            end
            k = pick(mask, model_ptr);
            ra = req_data1[32*k +: 32];
            rb = req_data2[32*k +: 32];
            rc = req_data3[32*k +: 32];
            expect_txn(k, fpu_model(req_select[5*k +: 5], ra, rb, rc),
                       $sformatf("rand%0d", it), 1'b0, 1'b0, w);
            req = '0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
